bcd_ctr_n: RTL
==============

Name: bcd_ctr_n

Overview:
Parametrised N-digit BCD up/down counter with synchronous load, programmable inclusive upper limit, and run-time selectable wrap or saturate mode. Next-generation replacement for the fixed four-digit decade counter used in the display/timer datapath. Feeds seven-segment decode logic. Cascades to wider counts via co/en chaining.

Parameters:
DIGITS, 4, number of BCD digits; counter width W = 4*DIGITS bits, digit 0 in bits [3:0] (least significant).

Ports:
clk    in   1  rising-edge clock
clr_n  in   1  asynchronous active-low clear
en     in   1  count enable, active high
ld     in   1  synchronous load, active high
up     in   1  1 = count up, 0 = count down
sat    in   1  1 = saturate at bounds, 0 = wrap
d      in   W  BCD load value
lim    in   W  BCD inclusive upper bound of the count range
q      out  W  current BCD count
co     out  1  combinational terminal count, for cascading
wrap   out  1  registered one-cycle pulse, asserted after a wrap step

Behaviour:
- Reset: clr_n low forces q=0 and wrap=0 immediately, independent of clk. Deassertion is sampled at the next rising clk edge.
- Digit clamp: any nibble of d or lim above 9 is treated as 9. This gives clamped values dc and lc. q never holds a nibble above 9.
- Priority at a rising edge, with clr_n high: ld, then en-count, then hold.
- Load (ld=1): q <= min(dc, lc). Load is independent of en. Load sets wrap <= 0. Load overrides counting in the same cycle.
- Hold (ld=0, en=0): q unchanged, wrap <= 0.
- Count up (ld=0, en=1, up=1):
  - q < lc: q <= q+1 in BCD. Digit i increments when every lower digit is 9; each digit that rolls over returns 9 -> 0.
  - q >= lc, sat=0: q <= 0, wrap <= 1.
  - q >= lc, sat=1: q <= lc, wrap <= 0.
- Count down (ld=0, en=1, up=0):
  - q > lc: q <= lc, wrap <= 0. This covers lim lowered while running.
  - 0 < q <= lc: q <= q-1 in BCD. Digit i decrements when every lower digit is 0; each digit that rolls under returns 0 -> 9.
  - q = 0, sat=0: q <= lc, wrap <= 1.
  - q = 0, sat=1: q <= 0, wrap <= 0.
- wrap is high for exactly one cycle, the cycle after the wrapping edge. It is low on every non-wrapping step.
- co = en & ((up & q >= lc) | (~up & q == 0)). co is combinational, with no added latency.
- Cascading: feed a higher stage with en_hi = en_lo & co_lo, set that stage's lim to all 9s, and share ld, up, sat and clk.
- Comparisons: unsigned, on clamped BCD values digit by digit, most significant digit first.
- lc = 0: the count is pinned at 0. Up or down with sat=0 produces wrap=1 on every enabled cycle.
- Mid-operation clr_n: the async clear wins over ld and en in the same cycle. There is no partial update.
- Changing up, sat or lim takes effect on the next edge.
- No X propagation: with d and lim driven, all outputs are defined from reset onward.

Test Plan:
1. Reset and load: assert clr_n=0 mid-count -> q=0 and wrap=0 before the next edge. Release, then ld=1 with d=16'h12A4 and lim=16'h9999 -> q=16'h1294 (nibble A clamped to 9).
2. Up-wrap at limit: DIGITS=4, lim=16'h0059, sat=0, load 16'h0058, en=1, up=1 for 3 cycles -> q=0059, 0000, 0001. wrap is high only in the cycle q=0000. co=1 while q=0059.
3. Down-wrap and saturate: lim=16'h0059, load 16'h0001, up=0, sat=0 for 3 cycles -> q=0000, 0059, 0058. Repeat with sat=1 -> q=0000, 0000, 0000 with wrap=0.
4. BCD digit ripple: lim=9999, load 16'h0999, up=1 for 1 edge -> 1000. Then up=0 for 1 edge -> 0999. No nibble above 9 ever appears on q.
5. Limit lowered while running: q=16'h0080, change lim to 16'h0050. With up=1 -> q=0000, wrap=1. Alternatively with up=0 -> q=0050. Load d=0090 -> q=0050.
6. Cascade: two DIGITS=2 instances chained via co to en, shared ld/up/sat, lim=99 on both. Count up from 0098 for 3 edges -> combined 0099, 0100, 0101. Count down from 0100 -> 0099.

Source files
------------

// File: rtl/bcd_ctr_n.sv
// N-digit BCD up/down counter with load, inclusive upper limit, and wrap/saturate mode.
// co is combinational terminal count for cascading; wrap pulses one cycle after a wrap step.

module bcd_digit (
  input  logic [3:0] q,
  input  logic [3:0] d,
  input  logic [3:0] lim,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] dc,
  output logic [3:0] lc,
  output logic [3:0] q_inc,
  output logic [3:0] q_dec
);
  always_comb begin
    dc    = (d   > 4'd9) ? 4'd9 : d;
    lc    = (lim > 4'd9) ? 4'd9 : lim;
    q_inc = q;
    q_dec = q;
    if (cin) q_inc = (q == 4'd9) ? 4'd0 : q + 4'd1;
    if (bin) q_dec = (q == 4'd0) ? 4'd9 : q - 4'd1;
  end
endmodule

module bcd_ctr_n #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic                  ld,
  input  logic                  up,
  input  logic                  sat,
  input  logic [4*DIGITS-1:0]   d,
  input  logic [4*DIGITS-1:0]   lim,
  output logic [4*DIGITS-1:0]   q,
  output logic                  co,
  output logic                  wrap
);
  logic [DIGITS-1:0][3:0] q_r, q_nxt, dc_v, lc_v, inc_v, dec_v;
  logic [DIGITS-1:0]      cy, bw;
  logic                   wrap_nxt, ge, gt, zero;

  // cy[g]: all lower digits are 9 (increment ripples in); bw[g]: all lower are 0.
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      if (g > 0) begin : g_chain
        assign cy[g] = cy[g-1] & (q_r[g-1] == 4'd9);
        assign bw[g] = bw[g-1] & (q_r[g-1] == 4'd0);
      end
      bcd_digit u_dig (
        .q    (q_r[g]),
        .d    (d[4*g +: 4]),
        .lim  (lim[4*g +: 4]),
        .cin  (cy[g]),
        .bin  (bw[g]),
        .dc   (dc_v[g]),
        .lc   (lc_v[g]),
        .q_inc(inc_v[g]),
        .q_dec(dec_v[g])
      );
    end
  endgenerate

  // Every nibble is <= 9, so packed compare equals digit-wise MSD-first compare.
  assign ge   = (q_r >= lc_v);
  assign gt   = (q_r >  lc_v);
  assign zero = (q_r == '0);
  assign co   = en & ((up & ge) | (~up & zero));
  assign q    = q_r;

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (ld) begin
      q_nxt = (dc_v < lc_v) ? dc_v : lc_v;
    end else if (en) begin
      if (up) begin
        if (!ge)      q_nxt = inc_v;
        else if (sat) q_nxt = lc_v;
        else begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (gt)         q_nxt = lc_v;
        else if (!zero) q_nxt = dec_v;
        else if (!sat) begin
          q_nxt    = lc_v;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r  <= '0;
      wrap <= 1'b0;
    end else begin
      q_r  <= q_nxt;
      wrap <= wrap_nxt;
    end
  end
endmodule
